// File: rtl/burst_mem_pkg.sv
`default_nettype none
// ============================================================================
// burst_mem_pkg : shared types and constants for the burst memory responder
// Rev 1.0
// ============================================================================
package burst_mem_pkg;

    localparam int BEAT_W   = 64;
    localparam int BEATS    = 4;
    localparam int LINE_W   = 256;
    localparam int OFFSET_W = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        WAIT  = 2'd1,
        BURST = 2'd2,
        DONE  = 2'd3
    } bm_state_t;

    typedef logic [LINE_W-1:0] line_t;

    function automatic logic [BEAT_W-1:0] beat_of(input line_t line, input logic [1:0] beat);
        return line[beat * BEAT_W +: BEAT_W];
    endfunction

endpackage
`default_nettype wire

// File: rtl/line_ram.sv
`default_nettype none
// ============================================================================
// line_ram : full-line RAM, 1-cycle synchronous read, write wins on collision
// Rev 1.0
// ============================================================================
module line_ram
    import burst_mem_pkg::*;
#(
    parameter int LINES = 256
) (
    input  logic                     clk,
    input  logic                     re_i,
    input  logic [$clog2(LINES)-1:0] raddr_i,
    output line_t                    rdata_o,
    input  logic                     we_i,
    input  logic [$clog2(LINES)-1:0] waddr_i,
    input  line_t                    wdata_i
);

    line_t ram_q [LINES];
    line_t rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            ram_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i : ram_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/burst_mem_responder.sv
`default_nettype none
// ============================================================================
// burst_mem_responder : 64-bit x 4-beat burst memory target with access latency
// Rev 1.0
// ============================================================================
module burst_mem_responder
    import burst_mem_pkg::*;
#(
    parameter int LINES   = 256,
    parameter int LATENCY = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [31:0] mem_addr,
    input  logic [63:0] mem_wdata,
    output logic        mem_resp,
    output logic [63:0] mem_rdata,
    output logic        busy,
    output logic        proto_err
);

    localparam int IDX_W = $clog2(LINES);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    bm_state_t                      state_q;
    logic [CNT_W-1:0]               cnt_q;
    logic [1:0]                     beat_q;
    logic [IDX_W-1:0]               idx_q;
    logic                           wr_q;
    logic                           proto_err_q;
    logic [(BEATS-1)*BEAT_W-1:0]    wbuf_q;

    logic [IDX_W-1:0] w_idx;
    logic             w_op_held;
    logic             w_ram_re;
    logic             w_ram_we;
    line_t            w_ram_rdata;
    logic             unused_addr_bits;

    assign w_idx            = mem_addr[OFFSET_W +: IDX_W];
    assign unused_addr_bits = ^{mem_addr[31:OFFSET_W+IDX_W], mem_addr[OFFSET_W-1:0]};
    assign w_op_held        = wr_q ? mem_write : mem_read;

    // A simultaneous read+write request is serviced as a write, so no read is needed.
    assign w_ram_re = (state_q == IDLE) && mem_read && !mem_write;
    assign w_ram_we = (state_q == BURST) && wr_q && mem_write && (beat_q == 2'(BEATS-1));

    line_ram #(
        .LINES(LINES)
    ) u_line_ram (
        .clk    (clk),
        .re_i   (w_ram_re),
        .raddr_i(w_idx),
        .rdata_o(w_ram_rdata),
        .we_i   (w_ram_we),
        .waddr_i(idx_q),
        .wdata_i({mem_wdata, wbuf_q})
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            beat_q      <= '0;
            idx_q       <= '0;
            wr_q        <= 1'b0;
            proto_err_q <= 1'b0;
            wbuf_q      <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mem_read || mem_write) begin
                        idx_q  <= w_idx;
                        wr_q   <= mem_write;
                        cnt_q  <= CNT_W'(LATENCY - 1);
                        beat_q <= '0;
                        if (mem_read && mem_write) begin
                            proto_err_q <= 1'b1;
                        end
                        state_q <= (LATENCY == 1) ? BURST : WAIT;
                    end
                end
                WAIT: begin
                    if (!w_op_held) begin
                        proto_err_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                        if (cnt_q == CNT_W'(1)) begin
                            state_q <= BURST;
                        end
                    end
                end
                BURST: begin
                    if (!w_op_held) begin
                        proto_err_q <= 1'b1;
                        state_q     <= IDLE;
                    end else begin
                        // Beat 3 bypasses the buffer and goes straight to the RAM write port.
                        if (wr_q) begin
                            case (beat_q)
                                2'd0:    wbuf_q[0*BEAT_W +: BEAT_W] <= mem_wdata;
                                2'd1:    wbuf_q[1*BEAT_W +: BEAT_W] <= mem_wdata;
                                2'd2:    wbuf_q[2*BEAT_W +: BEAT_W] <= mem_wdata;
                                default: ;
                            endcase
                        end
                        beat_q <= beat_q + 1'b1;
                        if (beat_q == 2'(BEATS-1)) begin
                            state_q <= DONE;
                        end
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign mem_resp  = (state_q == BURST);
    assign busy      = (state_q != IDLE);
    assign proto_err = proto_err_q;
    assign mem_rdata = ((state_q == BURST) && !wr_q) ? beat_of(w_ram_rdata, beat_q) : '0;

endmodule
`default_nettype wire

// File: tb/tb_burst_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_burst_mem_responder : directed self-checking bench (LATENCY 10 and 1 instances)
// Rev 1.0
// ============================================================================
module tb_burst_mem_responder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sel = 1'b0;
    logic        rd = 1'b0;
    logic        wr = 1'b0;
    logic [31:0] addr = '0;
    logic [63:0] wdata = '0;
    int          cyc = 0;
    int          n_cmp = 0;
    int          n_err = 0;

    logic        rd_a, wr_a, rd_b, wr_b;
    logic        resp_a, resp_b, busy_a, busy_b, perr_a, perr_b;
    logic [63:0] rdata_a, rdata_b;
    logic        resp, busy, perr;
    logic [63:0] rdata;

    assign rd_a  = rd & ~sel;
    assign wr_a  = wr & ~sel;
    assign rd_b  = rd & sel;
    assign wr_b  = wr & sel;
    assign resp  = sel ? resp_b  : resp_a;
    assign busy  = sel ? busy_b  : busy_a;
    assign perr  = sel ? perr_b  : perr_a;
    assign rdata = sel ? rdata_b : rdata_a;

    burst_mem_responder #(.LINES(256), .LATENCY(10)) u_dut_a (
        .clk(clk), .rst(rst), .mem_read(rd_a), .mem_write(wr_a), .mem_addr(addr),
        .mem_wdata(wdata), .mem_resp(resp_a), .mem_rdata(rdata_a), .busy(busy_a),
        .proto_err(perr_a)
    );

    burst_mem_responder #(.LINES(256), .LATENCY(1)) u_dut_b (
        .clk(clk), .rst(rst), .mem_read(rd_b), .mem_write(wr_b), .mem_addr(addr),
        .mem_wdata(wdata), .mem_resp(resp_b), .mem_rdata(rdata_b), .busy(busy_b),
        .proto_err(perr_b)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One line transfer. For writes d0..d3 are driven, for reads they are expected.
    // drop_beat / rst_beat >= 0 inject a request drop or a reset in that beat.
    task automatic xfer(input bit dut, input bit do_rd, input bit do_wr, input logic [31:0] a,
                        input logic [63:0] d0, input logic [63:0] d1,
                        input logic [63:0] d2, input logic [63:0] d3,
                        input int drop_beat, input int rst_beat, input int exp_lat,
                        input string tag);
        logic [63:0] d [4];
        int t0;
        int n;
        d = '{d0, d1, d2, d3};
        sel = dut;
        @(posedge clk); #1;
        addr = a; rd = do_rd; wr = do_wr; wdata = d0;
        @(posedge clk); #1;
        t0 = cyc;
        n = 0;
        @(negedge clk);
        while (!resp && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " latency"}, 64'(cyc - t0 + 1), 64'(exp_lat));
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            if (k == drop_beat) begin
                rd = 1'b0; wr = 1'b0;
                @(negedge clk);
                chk({tag, " abort resp"}, 64'(resp), 64'd0);
                chk({tag, " abort busy"}, 64'(busy), 64'd0);
                chk({tag, " abort proto_err"}, 64'(perr), 64'd1);
                return;
            end
            if (k == rst_beat) begin
                rst = 1'b1; rd = 1'b0; wr = 1'b0;
                @(posedge clk); #1;
                chk({tag, " rst resp"}, 64'(resp), 64'd0);
                chk({tag, " rst rdata"}, rdata, 64'd0);
                chk({tag, " rst busy"}, 64'(busy), 64'd0);
                chk({tag, " rst proto_err"}, 64'(perr), 64'd0);
                rst = 1'b0;
                return;
            end
            chk($sformatf("%s resp beat%0d", tag, k), 64'(resp), 64'd1);
            if (do_wr) wdata = d[k];
            else chk($sformatf("%s rdata beat%0d", tag, k), rdata, d[k]);
        end
        @(posedge clk); #1;
        rd = 1'b0; wr = 1'b0;
        @(negedge clk);
        chk({tag, " done resp"}, 64'(resp), 64'd0);
        chk({tag, " done busy"}, 64'(busy), 64'd1);
        @(posedge clk);
    endtask

    initial begin
        int t0;
        int n;
        logic [63:0] l1 [4];
        logic [63:0] l2 [4];
        l1 = '{64'h0101_0101_0101_0100, 64'h0101_0101_0101_0101,
               64'h0101_0101_0101_0102, 64'h0101_0101_0101_0103};
        l2 = '{64'h0202_0202_0202_0200, 64'h0202_0202_0202_0201,
               64'h0202_0202_0202_0202, 64'h0202_0202_0202_0203};

        repeat (3) @(posedge clk);
        #1;
        chk("reset resp_a", 64'(resp_a), 64'd0);
        chk("reset rdata_a", rdata_a, 64'd0);
        chk("reset busy_a", 64'(busy_a), 64'd0);
        chk("reset perr_a", 64'(perr_a), 64'd0);
        chk("reset resp_b", 64'(resp_b), 64'd0);
        chk("reset busy_b", 64'(busy_b), 64'd0);
        rst = 1'b0;

        // Write then read back, LATENCY 10
        xfer(0, 0, 1, 32'h0000_0100, {4{16'h1111}}, {4{16'h2222}}, {4{16'h3333}}, {4{16'h4444}},
             -1, -1, 10, "wr100");
        chk("wr100 proto_err", 64'(perr), 64'd0);
        xfer(0, 1, 0, 32'h0000_0100, {4{16'h1111}}, {4{16'h2222}}, {4{16'h3333}}, {4{16'h4444}},
             -1, -1, 10, "rd100");
        chk("rd100 proto_err", 64'(perr), 64'd0);

        // Aliasing modulo 8 KiB and ignored offset bits
        xfer(0, 0, 1, 32'h0000_2000, 64'hDEAD_0000_0000_0000, 64'hDEAD_0000_0000_0001,
             64'hDEAD_0000_0000_0002, 64'hDEAD_0000_0000_0003, -1, -1, 10, "wr2000");
        xfer(0, 1, 0, 32'h0000_0000, 64'hDEAD_0000_0000_0000, 64'hDEAD_0000_0000_0001,
             64'hDEAD_0000_0000_0002, 64'hDEAD_0000_0000_0003, -1, -1, 10, "rd0000");
        xfer(0, 1, 0, 32'h0000_001F, 64'hDEAD_0000_0000_0000, 64'hDEAD_0000_0000_0001,
             64'hDEAD_0000_0000_0002, 64'hDEAD_0000_0000_0003, -1, -1, 10, "rd001F");

        // Dropped write leaves the old line intact
        xfer(0, 0, 1, 32'h0000_00C0, {4{16'h5555}}, {4{16'h5555}}, {4{16'h5555}}, {4{16'h5555}},
             -1, -1, 10, "wr55");
        chk("wr55 proto_err", 64'(perr), 64'd0);
        xfer(0, 0, 1, 32'h0000_00C0, {4{16'h9999}}, {4{16'h9999}}, {4{16'h9999}}, {4{16'h9999}},
             2, -1, 10, "drop");
        xfer(0, 1, 0, 32'h0000_00C0, {4{16'h5555}}, {4{16'h5555}}, {4{16'h5555}}, {4{16'h5555}},
             -1, -1, 10, "rd55");

        // Reset in beat 2 of a read, then data still present
        xfer(0, 1, 0, 32'h0000_00C0, {4{16'h5555}}, {4{16'h5555}}, {4{16'h5555}}, {4{16'h5555}},
             -1, 2, 10, "rstrd");
        xfer(0, 1, 0, 32'h0000_00C0, {4{16'h5555}}, {4{16'h5555}}, {4{16'h5555}}, {4{16'h5555}},
             -1, -1, 10, "rd55b");
        chk("rd55b proto_err", 64'(perr), 64'd0);

        // Read and write together: serviced as a write, flagged
        xfer(0, 1, 1, 32'h0000_00A0, {4{16'hAAAA}}, {4{16'hAAAA}}, {4{16'hAAAA}}, {4{16'hAAAA}},
             -1, -1, 10, "both");
        chk("both proto_err", 64'(perr), 64'd1);
        xfer(0, 1, 0, 32'h0000_00A0, {4{16'hAAAA}}, {4{16'hAAAA}}, {4{16'hAAAA}}, {4{16'hAAAA}},
             -1, -1, 10, "rdAA");

        // LATENCY 1 instance: fill lines 1 and 2, then back-to-back reads
        xfer(1, 0, 1, 32'h0000_0020, l1[0], l1[1], l1[2], l1[3], -1, -1, 1, "b_wr1");
        xfer(1, 0, 1, 32'h0000_0040, l2[0], l2[1], l2[2], l2[3], -1, -1, 1, "b_wr2");
        sel = 1'b1;
        @(posedge clk); #1;
        addr = 32'h0000_0020; rd = 1'b1;
        @(posedge clk); #1;
        t0 = cyc;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("b2b first resp cyc%0d", k), 64'(resp), 64'd1);
            chk($sformatf("b2b first rdata%0d", k), rdata, l1[k]);
        end
        @(posedge clk); #1;
        addr = 32'h0000_0040;
        @(negedge clk);
        chk("b2b done resp", 64'(resp), 64'd0);
        n = 0;
        @(negedge clk);
        while (!resp && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("b2b second start offset", 64'(cyc - t0), 64'd6);
        for (int k = 0; k < 4; k++) begin
            if (k > 0) @(negedge clk);
            chk($sformatf("b2b second resp%0d", k), 64'(resp), 64'd1);
            chk($sformatf("b2b second rdata%0d", k), rdata, l2[k]);
        end
        @(posedge clk); #1;
        rd = 1'b0;
        chk("b2b proto_err", 64'(perr), 64'd0);
        repeat (3) @(posedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
